// File: rtl/alu_hs.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply,
// registered result and flags held until the consumer takes them, plus an internal accumulator.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// BUSY  | multiply in progress, one shift-add step per edge
// DONE  | out_valid=1, result held until out_ready
module alu_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] acc
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                    accept;
  logic [WIDTH-1:0]        opa;
  logic [SHW-1:0]          shamt;

  logic [WIDTH:0]          sum_ext;
  logic [WIDTH:0]          dif_ext;
  logic                    add_v;
  logic                    sub_v;
  logic [WIDTH:0]          sll_ext;
  logic [WIDTH:0]          srl_ext;
  logic signed [WIDTH:0]   sra_ext;

  logic [WIDTH-1:0]        res_y;
  logic                    res_c;
  logic                    res_v;
  logic                    res_legal;

  logic [2*WIDTH-1:0]      mcand;
  logic [2*WIDTH-1:0]      prod;
  logic [2*WIDTH-1:0]      prod_step;
  logic [WIDTH-1:0]        mplier;
  logic [SHW-1:0]          cnt;
  logic                    mul_last;

  assign accept = in_valid && in_ready;
  assign opa    = use_acc ? acc : a;
  assign shamt  = b[SHW-1:0];

  assign sum_ext = {1'b0, opa} + {1'b0, b};
  assign dif_ext = {1'b0, opa} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v   = (opa[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != opa[WIDTH-1]);
  assign sub_v   = (opa[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != opa[WIDTH-1]);

  // Extra bit beside the operand catches the last bit shifted out; it stays 0 for a zero shift.
  assign sll_ext = {1'b0, opa} << shamt;
  assign srl_ext = {opa, 1'b0} >> shamt;
  assign sra_ext = $signed({opa, 1'b0}) >>> shamt;

  always_comb begin
    res_y     = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_legal = 1'b1;
    case (op)
      OP_AND: res_y = opa & b;
      OP_OR:  res_y = opa | b;
      OP_XOR: res_y = opa ^ b;
      OP_ADD: begin
        res_y = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
        res_v = add_v;
      end
      OP_SUB: begin
        res_y = dif_ext[WIDTH-1:0];
        res_c = dif_ext[WIDTH];
        res_v = sub_v;
      end
      OP_SLT: begin
        res_y = {{(WIDTH-1){1'b0}}, dif_ext[WIDTH-1] ^ sub_v};
        res_c = dif_ext[WIDTH];
        res_v = sub_v;
      end
      OP_SLL: begin
        res_y = sll_ext[WIDTH-1:0];
        res_c = sll_ext[WIDTH];
      end
      OP_SRL: begin
        res_y = srl_ext[WIDTH:1];
        res_c = srl_ext[0];
      end
      OP_SRA: begin
        res_y = sra_ext[WIDTH:1];
        res_c = sra_ext[0];
      end
      OP_MUL:  res_legal = 1'b1;
      default: res_legal = 1'b0;
    endcase
  end

  assign prod_step = prod + (mplier[0] ? mcand : '0);
  assign mul_last  = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (op == OP_MUL) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y         <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand  <= {{WIDTH{1'b0}}, opa};
        mplier <= b;
        prod   <= '0;
        cnt    <= SHW'(WIDTH - 1);
      end else begin
        y         <= res_y;
        zero      <= (res_y == '0);
        carry_out <= res_c;
        overflow  <= res_v;
      end
    end else if (state == BUSY) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - SHW'(1);
      if (mul_last) begin
        y         <= prod_step[WIDTH-1:0];
        zero      <= (prod_step[WIDTH-1:0] == '0);
        carry_out <= |prod_step[2*WIDTH-1:WIDTH];
        overflow  <= 1'b0;
      end
    end
  end

  // Clear has priority over any result write landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept && (op != OP_MUL) && res_legal) begin
      acc <= res_y;
    end else if (mul_last) begin
      acc <= prod_step[WIDTH-1:0];
    end
  end

endmodule
